// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and default sizes for the Sobel window datapath
package sobel_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_DEF   = 3;

    typedef enum logic [1:0] {DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP} shift_dir_t;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

endpackage

// File: rtl/window_fill_seq.sv
// rtl/window_fill_seq.sv - generates the refill slot sequence (edge row/column or full raster)
module window_fill_seq
    import sobel_pkg::*;
#(
    parameter  int WIN   = WIN_DEF,
    localparam int IDX_W = $clog2(WIN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             load_i,
    input  shift_dir_t       dir_i,
    input  logic             beat_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

    logic             active_q, active_d;
    logic             load_q, load_d;
    shift_dir_t       dir_q, dir_d;
    logic [IDX_W-1:0] maj_q, maj_d;
    logic [IDX_W-1:0] min_q, min_d;

    // Shifts only walk the minor counter; loads walk it as the raster column.
    always_comb begin
        last_o = active_q && (min_q == LAST_IDX) && (!load_q || (maj_q == LAST_IDX));
    end

    always_comb begin
        active_d = active_q;
        load_d   = load_q;
        dir_d    = dir_q;
        maj_d    = maj_q;
        min_d    = min_q;
        if (start_i) begin
            active_d = 1'b1;
            load_d   = load_i;
            dir_d    = dir_i;
            maj_d    = '0;
            min_d    = '0;
        end else if (active_q && beat_i) begin
            if (min_q == LAST_IDX) begin
                min_d = '0;
                if (load_q) begin
                    maj_d = (maj_q == LAST_IDX) ? '0 : maj_q + 1'b1;
                end
            end else begin
                min_d = min_q + 1'b1;
            end
            if (last_o) begin
                active_d = 1'b0;
            end
        end
    end

    always_comb begin
        row_o = '0;
        col_o = '0;
        if (active_q) begin
            if (load_q) begin
                row_o = maj_q;
                col_o = min_q;
            end else begin
                case (dir_q)
                    DIR_RIGHT: begin row_o = min_q;    col_o = LAST_IDX; end
                    DIR_DOWN:  begin row_o = LAST_IDX; col_o = min_q;    end
                    DIR_LEFT:  begin row_o = min_q;    col_o = '0;       end
                    default:   begin row_o = '0;       col_o = min_q;    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            load_q   <= 1'b0;
            dir_q    <= DIR_RIGHT;
            maj_q    <= '0;
            min_q    <= '0;
        end else begin
            active_q <= active_d;
            load_q   <= load_d;
            dir_q    <= dir_d;
            maj_q    <= maj_d;
            min_q    <= min_d;
        end
    end

endmodule

// File: rtl/window_shift_buffer.sv
// rtl/window_shift_buffer.sv - KxK pixel window with directional shift, edge refill and full load
module window_shift_buffer
    import sobel_pkg::*;
#(
    parameter  int PIX_W = PIX_W_DEF,
    parameter  int WIN   = WIN_DEF,
    localparam int IDX_W = $clog2(WIN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_shift,
    input  logic                     start_load,
    input  logic [1:0]               shift_direc,
    output logic                     rd_req,
    output logic [IDX_W-1:0]         rd_row,
    output logic [IDX_W-1:0]         rd_col,
    input  logic                     rd_valid,
    input  logic [PIX_W-1:0]         rd_data,
    output logic                     busy,
    output logic                     shift_done,
    output logic                     load_done,
    output logic [WIN*WIN*PIX_W-1:0] window
);

    state_t                     state_q, state_d;
    logic                       is_load_q, is_load_d;
    logic [WIN*WIN*PIX_W-1:0]   win_q, win_d;
    logic                       accept, beat, seq_last;
    shift_dir_t                 dir_in;
    int                         wr_idx;

    assign dir_in = shift_dir_t'(shift_direc);
    assign accept = (state_q == IDLE) && (start_load || start_shift);
    assign rd_req = (state_q == FETCH);
    assign beat   = rd_req && rd_valid;
    assign wr_idx = int'(rd_row) * WIN + int'(rd_col);

    window_fill_seq #(.WIN(WIN)) u_fill_seq (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept),
        .load_i  (start_load),
        .dir_i   (dir_in),
        .beat_i  (beat),
        .row_o   (rd_row),
        .col_o   (rd_col),
        .last_o  (seq_last)
    );

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = FETCH;
                    is_load_d = start_load;
                end
            end
            FETCH:   if (beat && seq_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift source index is clamped so the vacated edge never reads outside the array.
    always_comb begin
        win_d = win_q;
        if (accept && !start_load) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    int   src;
                    logic keep;
                    case (dir_in)
                        DIR_RIGHT: begin keep = (c < WIN - 1); src = keep ? r * WIN + c + 1   : r * WIN + c; end
                        DIR_DOWN:  begin keep = (r < WIN - 1); src = keep ? (r + 1) * WIN + c : r * WIN + c; end
                        DIR_LEFT:  begin keep = (c > 0);       src = keep ? r * WIN + c - 1   : r * WIN + c; end
                        default:   begin keep = (r > 0);       src = keep ? (r - 1) * WIN + c : r * WIN + c; end
                    endcase
                    win_d[(r*WIN+c)*PIX_W +: PIX_W] = keep ? win_q[src*PIX_W +: PIX_W] : '0;
                end
            end
        end else if (beat) begin
            for (int i = 0; i < WIN * WIN; i++) begin
                if (i == wr_idx) begin
                    win_d[i*PIX_W +: PIX_W] = rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            win_q     <= win_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign shift_done = (state_q == DONE) && !is_load_q;
    assign load_done  = (state_q == DONE) && is_load_q;
    assign window     = win_q;

endmodule

// File: tb/tb_window_shift_buffer.sv
// tb/tb_window_shift_buffer.sv - directed bench for window_shift_buffer (WIN=3, PIX_W=8)
module tb_window_shift_buffer;

    localparam int PIX_W = 8;
    localparam int WIN   = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start_shift = 1'b0;
    logic                     start_load = 1'b0;
    logic [1:0]               shift_direc = 2'b00;
    logic                     rd_req;
    logic [1:0]               rd_row, rd_col;
    logic                     rd_valid = 1'b0;
    logic [PIX_W-1:0]         rd_data = '0;
    logic                     busy, shift_done, load_done;
    logic [WIN*WIN*PIX_W-1:0] window;

    window_shift_buffer #(.PIX_W(PIX_W), .WIN(WIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_shift (start_shift),
        .start_load  (start_load),
        .shift_direc (shift_direc),
        .rd_req      (rd_req),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .shift_done  (shift_done),
        .load_done   (load_done),
        .window      (window)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mem_data [9];
    int         done_cyc, sdone_cnt, ldone_cnt, nbeats;
    logic       busy_after;
    bit         stable_ok;
    logic [1:0] log_row [9];
    logic [1:0] log_col [9];
    logic [7:0] snap1 [9];

    function automatic logic [7:0] pix(input int i);
        return window[i*PIX_W +: PIX_W];
    endfunction

    // Drives one operation and models the memory: waits cycles of stall before each beat.
    task automatic op(input logic ld, input logic sh, input logic [1:0] dir, input int waits, input int poke_cyc);
        int         wc;
        bit         holding, seen;
        logic [1:0] hr, hc;
        done_cyc = -1; sdone_cnt = 0; ldone_cnt = 0; nbeats = 0; stable_ok = 1;
        wc = 0; holding = 0; seen = 0; hr = 0; hc = 0;
        @(negedge clk);
        start_load = ld; start_shift = sh; shift_direc = dir; rd_valid = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
            @(negedge clk);
            start_load  = 1'b0;
            start_shift = (cyc == poke_cyc);
            shift_direc = ~dir;
            if (cyc == 1) for (int i = 0; i < 9; i++) snap1[i] = pix(i);
            if (shift_done) sdone_cnt++;
            if (load_done) ldone_cnt++;
            if (shift_done || load_done) begin
                done_cyc = cyc;
                seen = 1;
            end
            if (rd_req) begin
                if (holding && (rd_row !== hr || rd_col !== hc)) stable_ok = 0;
                if (wc < waits) begin
                    rd_valid = 1'b0; holding = 1; hr = rd_row; hc = rd_col; wc++;
                end else begin
                    rd_valid = 1'b1;
                    rd_data  = mem_data[nbeats < 9 ? nbeats : 0];
                    if (nbeats < 9) begin
                        log_row[nbeats] = rd_row;
                        log_col[nbeats] = rd_col;
                    end
                    nbeats++; wc = 0; holding = 0;
                end
            end else begin
                rd_valid = 1'b0;
            end
        end
        start_shift = 1'b0;
        rd_valid    = 1'b0;
        if (!seen) begin
            errors++; checks++;
            $display("FAIL op_timeout: no done pulse within 200 cycles");
        end
        @(negedge clk);
        busy_after = busy;
        if (shift_done) sdone_cnt++;
        if (load_done) ldone_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (window !== '0) begin errors++; $display("FAIL reset_window: got %h want 0", window); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
        checks++; if (rd_row !== 2'd0 || rd_col !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d,%0d want 0,0", rd_row, rd_col); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (shift_done !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b%b want 00", shift_done, load_done); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        for (int i = 0; i < 9; i++) mem_data[i] = 8'(50 + i);
        op(1'b1, 1'b0, 2'b00, 0, -1);
        checks++; if (done_cyc !== 10) begin errors++; $display("FAIL load_latency: got %0d want 10", done_cyc); end
        checks++; if (ldone_cnt !== 1 || sdone_cnt !== 0) begin errors++; $display("FAIL load_pulses: got l=%0d s=%0d want l=1 s=0", ldone_cnt, sdone_cnt); end
        checks++; if (nbeats !== 9) begin errors++; $display("FAIL load_beats: got %0d want 9", nbeats); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL load_busy_after: got %b want 0", busy_after); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (pix(i) !== 8'(50 + i)) begin errors++; $display("FAIL load_win[%0d]: got %0d want %0d", i, pix(i), 50 + i); end
            checks++;
            if (log_row[i] !== 2'(i / 3) || log_col[i] !== 2'(i % 3)) begin
                errors++; $display("FAIL load_addr[%0d]: got %0d,%0d want %0d,%0d", i, log_row[i], log_col[i], i / 3, i % 3);
            end
        end
    endtask

    task automatic test_shift_down();
        logic [7:0] exp [9];
        exp = '{53, 54, 55, 56, 57, 58, 60, 61, 62};
        mem_data[0] = 60; mem_data[1] = 61; mem_data[2] = 62;
        op(1'b0, 1'b1, 2'b01, 0, -1);
        checks++; if (done_cyc !== 4) begin errors++; $display("FAIL down_latency: got %0d want 4", done_cyc); end
        checks++; if (sdone_cnt !== 1 || ldone_cnt !== 0) begin errors++; $display("FAIL down_pulses: got s=%0d l=%0d want s=1 l=0", sdone_cnt, ldone_cnt); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (pix(i) !== exp[i]) begin errors++; $display("FAIL down_win[%0d]: got %0d want %0d", i, pix(i), exp[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_row[i] !== 2'd2 || log_col[i] !== 2'(i)) begin errors++; $display("FAIL down_addr[%0d]: got %0d,%0d want 2,%0d", i, log_row[i], log_col[i], i); end
        end
    endtask

    task automatic test_shift_right_wait();
        logic [7:0] exp [9];
        logic [7:0] exp_snap [9];
        exp      = '{54, 55, 70, 57, 58, 71, 61, 62, 72};
        exp_snap = '{54, 55, 0, 57, 58, 0, 61, 62, 0};
        mem_data[0] = 70; mem_data[1] = 71; mem_data[2] = 72;
        op(1'b0, 1'b1, 2'b00, 2, -1);
        checks++; if (done_cyc !== 10) begin errors++; $display("FAIL right_latency: got %0d want 10", done_cyc); end
        checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL right_idx_stable: got %b want 1", stable_ok); end
        checks++; if (nbeats !== 3) begin errors++; $display("FAIL right_beats: got %0d want 3", nbeats); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (pix(i) !== exp[i]) begin errors++; $display("FAIL right_win[%0d]: got %0d want %0d", i, pix(i), exp[i]); end
            checks++; if (snap1[i] !== exp_snap[i]) begin errors++; $display("FAIL right_shifted[%0d]: got %0d want %0d", i, snap1[i], exp_snap[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_row[i] !== 2'(i) || log_col[i] !== 2'd2) begin errors++; $display("FAIL right_addr[%0d]: got %0d,%0d want %0d,2", i, log_row[i], log_col[i], i); end
        end
    endtask

    task automatic test_shift_up_left();
        logic [7:0] exp_up [9];
        logic [7:0] exp_lf [9];
        logic [7:0] exp_snap [9];
        exp_up   = '{80, 81, 82, 54, 55, 70, 57, 58, 71};
        exp_lf   = '{90, 80, 81, 91, 54, 55, 92, 57, 58};
        exp_snap = '{0, 80, 81, 0, 54, 55, 0, 57, 58};
        mem_data[0] = 80; mem_data[1] = 81; mem_data[2] = 82;
        op(1'b0, 1'b1, 2'b11, 0, -1);
        checks++; if (done_cyc !== 4) begin errors++; $display("FAIL up_latency: got %0d want 4", done_cyc); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (pix(i) !== exp_up[i]) begin errors++; $display("FAIL up_win[%0d]: got %0d want %0d", i, pix(i), exp_up[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_row[i] !== 2'd0 || log_col[i] !== 2'(i)) begin errors++; $display("FAIL up_addr[%0d]: got %0d,%0d want 0,%0d", i, log_row[i], log_col[i], i); end
        end
        mem_data[0] = 90; mem_data[1] = 91; mem_data[2] = 92;
        op(1'b0, 1'b1, 2'b10, 1, -1);
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL left_latency: got %0d want 7", done_cyc); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (pix(i) !== exp_lf[i]) begin errors++; $display("FAIL left_win[%0d]: got %0d want %0d", i, pix(i), exp_lf[i]); end
            checks++; if (snap1[i] !== exp_snap[i]) begin errors++; $display("FAIL left_shifted[%0d]: got %0d want %0d", i, snap1[i], exp_snap[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_row[i] !== 2'(i) || log_col[i] !== 2'd0) begin errors++; $display("FAIL left_addr[%0d]: got %0d,%0d want %0d,0", i, log_row[i], log_col[i], i); end
        end
    endtask

    task automatic test_conflict_and_spurious();
        for (int i = 0; i < 9; i++) mem_data[i] = 8'(100 + i);
        op(1'b1, 1'b1, 2'b01, 0, 3);
        checks++; if (done_cyc !== 10) begin errors++; $display("FAIL conflict_latency: got %0d want 10", done_cyc); end
        checks++; if (ldone_cnt !== 1 || sdone_cnt !== 0) begin errors++; $display("FAIL conflict_pulses: got l=%0d s=%0d want l=1 s=0", ldone_cnt, sdone_cnt); end
        checks++; if (nbeats !== 9) begin errors++; $display("FAIL conflict_beats: got %0d want 9", nbeats); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL conflict_busy_after: got %b want 0", busy_after); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (pix(i) !== 8'(100 + i)) begin errors++; $display("FAIL conflict_win[%0d]: got %0d want %0d", i, pix(i), 100 + i); end
        end
        rd_valid = 1'b1; rd_data = 8'hEE;
        repeat (3) @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL spurious_idle: got busy=%b rd_req=%b want 0 0", busy, rd_req); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (pix(i) !== 8'(100 + i)) begin errors++; $display("FAIL spurious_win[%0d]: got %0d want %0d", i, pix(i), 100 + i); end
        end
    endtask

    task automatic test_reset_abort();
        int sd;
        sd = 0;
        @(negedge clk);
        start_shift = 1'b1; shift_direc = 2'b01;
        @(posedge clk);
        @(negedge clk);
        start_shift = 1'b0; rd_valid = 1'b1; rd_data = 8'd110;
        @(negedge clk);
        rd_data = 8'd111;
        @(negedge clk);
        rd_valid = 1'b0;
        checks++; if (pix(6) !== 8'd110 || pix(7) !== 8'd111) begin errors++; $display("FAIL abort_partial: got %0d,%0d want 110,111", pix(6), pix(7)); end
        if (shift_done) sd++;
        rst = 1'b1;
        @(negedge clk);
        if (shift_done) sd++;
        checks++; if (window !== '0) begin errors++; $display("FAIL abort_window: got %h want 0", window); end
        checks++; if (rd_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got rd_req=%b busy=%b want 0 0", rd_req, busy); end
        rst = 1'b0;
        @(negedge clk);
        if (shift_done) sd++;
        checks++; if (sd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", sd); end
        for (int i = 0; i < 9; i++) mem_data[i] = 8'(120 + i);
        op(1'b1, 1'b0, 2'b00, 0, -1);
        checks++; if (done_cyc !== 10 || ldone_cnt !== 1) begin errors++; $display("FAIL reload_done: got cyc=%0d cnt=%0d want 10 1", done_cyc, ldone_cnt); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (pix(i) !== 8'(120 + i)) begin errors++; $display("FAIL reload_win[%0d]: got %0d want %0d", i, pix(i), 120 + i); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_down();
        test_shift_right_wait();
        test_shift_up_left();
        test_conflict_and_spurious();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_shift_buffer.md
Name: window_shift_buffer

Overview:
Parametrised K×K pixel window register for the Sobel datapath. It is the successor to the fixed 3×3 shift-only window.
- Supports four shift directions.
- Refills the vacated edge row or column itself through a read handshake with pixel memory.
- Supports a full-window load mode.
- Issues single-cycle done pulses.

It sits between the image SRAM read port and the Sobel convolution unit.

Parameters:
PIX_W, 8, bits per pixel
WIN, 3, window edge length K (odd, 3..7)
IDX_W, $clog2(WIN), derived width of row/col indices (localparam)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start_shift  input  1  request shift plus edge refill (sampled in IDLE only)
start_load  input  1  request full-window load (sampled in IDLE only)
shift_direc  input  2  00 right, 01 down, 10 left, 11 up (sampled with start_shift)
rd_req  output  1  pixel read request
rd_row  output  IDX_W  window row of requested pixel
rd_col  output  IDX_W  window column of requested pixel
rd_valid  input  1  rd_data valid for current request
rd_data  input  PIX_W  returned pixel
busy  output  1  high in any state except IDLE
shift_done  output  1  one-cycle pulse when a shift+refill completes
load_done  output  1  one-cycle pulse when a full load completes
window  output  WIN*WIN*PIX_W  element (r,c) at slice index r*WIN+c, row 0 = top, col 0 = left

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, all window elements 0, rd_req=0, rd_row=rd_col=0, busy=0, both done pulses 0. Reset aborts any operation in progress with no done pulse.
- States: IDLE, FETCH, DONE.
- IDLE accept edge:
  - start_load=1: the window is left unchanged and the fill target is all WIN*WIN slots in raster order. start_load wins if start_shift is also 1.
  - start_shift=1: the shift happens on the accept edge. The vacated slots are cleared to 0.
  - Either accept moves the state to FETCH.
- Shift semantics, with "window moves" meaning the image position moves:
  - Right (00): element (r,c) takes (r,c+1). Refill column WIN-1, rows 0..WIN-1.
  - Down (01): element (r,c) takes (r+1,c). Refill row WIN-1, cols 0..WIN-1.
  - Left (10): element (r,c) takes (r,c-1). Refill column 0, rows top to bottom.
  - Up (11): element (r,c) takes (r-1,c). Refill row 0, cols left to right.
- FETCH:
  - rd_req=1, with rd_row/rd_col pointing at the current target slot.
  - On a cycle with rd_req=1 and rd_valid=1, rd_data is written to that slot and the counter advances.
  - rd_req stays high and the indices stay stable until rd_valid. Zero-wait (rd_valid in the same cycle as the first rd_req) is legal.
  - rd_valid while rd_req=0 is ignored.
- After the last beat (WIN beats for a shift, WIN*WIN for a load), the state moves to DONE and rd_req drops.
- DONE: the matching done pulse is high for exactly 1 cycle, then the state returns to IDLE. busy is low in that following IDLE cycle.
- Latency with zero-wait memory:
  - Shift: done is high in cycle WIN+1 after the accept edge (cycle 0).
  - Load: done is high in cycle WIN*WIN+1.
  - Each wait cycle adds 1.
- start_shift/start_load while busy are ignored, not queued.
- The window output is registered and changes only on an accept edge or a write beat. It is readable at all times.
- Index counters wrap to 0 at the end of each operation and never exceed WIN-1.
- shift_direc is latched on accept. Later changes during FETCH have no effect.

Decomposition:
- Package sobel_pkg:
  - typedef enum logic[1:0] shift_dir_t {DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP}
  - typedef enum state_t {IDLE, FETCH, DONE}
  - default PIX_W/WIN constants
- Sub-module window_fill_seq: given the mode and latched direction, it generates rd_row/rd_col and a last-beat flag, and advances on a beat. The window register array and shift logic stay in the top module.

Test Plan (WIN=3, PIX_W=8):
1. Reset, then load with zero-wait memory returning 50..58 in raster order -> load_done 10 cycles after accept; window = 50..58 at indices 0..8; busy low the next cycle.
2. From that state, shift down (01) returning 60,61,62 -> indices 0..5 = 53..58, 6..8 = 60,61,62; shift_done at cycle 4.
3. Shift right (00) with 2 wait cycles per beat, returning 70,71,72 -> column 2 = 70,71,72 top to bottom; columns 0/1 hold old columns 1/2; shift_done at cycle 10; rd_row/rd_col stable while waiting.
4. Shift up and shift left -> rd_row/rd_col sequences are (0,0),(0,1),(0,2) for up and (0,0),(1,0),(2,0) for left, with correct element moves.
5. start_shift and start_load in the same cycle -> load performed (9 beats, load_done only). start_shift pulsed mid-FETCH -> ignored, no extra beats. Spurious rd_valid in IDLE -> window unchanged.
6. rst asserted after 2 beats of a shift -> next cycle window all 0, rd_req 0, busy 0, no done pulse. A fresh load then completes normally.
